// File: rtl/vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_sync_gen                                                 |
// | Description : 640x480@60 VGA timing generator with combinational fetch     |
// |               coordinates and a two-stage registered sync/colour pipeline. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rgb_in,
    output logic [9:0] fetch_x,
    output logic [9:0] fetch_y,
    output logic       fetch_en,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb_out,
    output logic       video_on,
    output logic       frame_start,
    output logic       line_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Compare constants are one bit wider so a 1024-wide total still fits.
    localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [10:0] w_h_ext;
    logic [10:0] w_v_ext;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_hs_act;
    logic        w_vs_act;

    logic        r_s1_en;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_frame;
    logic        r_s1_line;

    logic        r_hsync;
    logic        r_vsync;
    logic [7:0]  r_rgb;
    logic        r_video_on;
    logic        r_frame_start;
    logic        r_line_start;

    assign w_h_ext  = {1'b0, r_h_cnt};
    assign w_v_ext  = {1'b0, r_v_cnt};
    assign w_h_last = (w_h_ext == c_H_LAST);
    assign w_v_last = (w_v_ext == c_V_LAST);
    assign w_h_act  = (w_h_ext < c_H_ACT);
    assign w_v_act  = (w_v_ext < c_V_ACT);
    assign w_hs_act = (w_h_ext >= c_HS_BEGIN) && (w_h_ext < c_HS_END);
    assign w_vs_act = (w_v_ext >= c_VS_BEGIN) && (w_v_ext < c_VS_END);

    assign fetch_x  = r_h_cnt;
    assign fetch_y  = r_v_cnt;
    assign fetch_en = w_h_act && w_v_act;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Stage 1 lines up the timing flags with the renderer's one-cycle fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_en    <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_frame <= 1'b0;
            r_s1_line  <= 1'b0;
        end else begin
            r_s1_en    <= fetch_en;
            r_s1_hs    <= w_hs_act;
            r_s1_vs    <= w_vs_act;
            r_s1_frame <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
            r_s1_line  <= (r_h_cnt == 10'd0) && w_v_act;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_rgb         <= 8'h00;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_hsync       <= r_s1_hs ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= r_s1_vs ? SYNC_POL : ~SYNC_POL;
            r_rgb         <= r_s1_en ? rgb_in : 8'h00;
            r_video_on    <= r_s1_en;
            r_frame_start <= r_s1_frame;
            r_line_start  <= r_s1_line;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_out     = r_rgb;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_sync_gen                                              |
// | Description : Directed bench: full-size instance for reset/line/data, and  |
// |               a shrunken active-high-sync instance for frame/reset timing. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size 640x480 instance
    logic       rst_n_a;
    logic       rom_mode;
    logic [7:0] rom_q_a;
    logic [7:0] rgb_in_a;
    logic [9:0] fx_a, fy_a;
    logic       fen_a, hs_a, vs_a, vid_a, fs_a, ls_a;
    logic [7:0] rgb_a;

    always_ff @(posedge clk) rom_q_a <= fx_a[7:0];
    assign rgb_in_a = rom_mode ? rom_q_a : 8'hFF;

    vga_sync_gen dut_a (
        .clk(clk), .rst_n(rst_n_a), .rgb_in(rgb_in_a),
        .fetch_x(fx_a), .fetch_y(fy_a), .fetch_en(fen_a),
        .hsync(hs_a), .vsync(vs_a), .rgb_out(rgb_a), .video_on(vid_a),
        .frame_start(fs_a), .line_start(ls_a)
    );

    // Small instance: line 25 cycles, frame 11 lines (275 cycles), sync active-high
    logic       rst_n_b;
    logic [9:0] fx_b, fy_b;
    logic       fen_b, hs_b, vs_b, vid_b, fs_b, ls_b;
    logic [7:0] rgb_b;

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .rgb_in(8'hFF),
        .fetch_x(fx_b), .fetch_y(fy_b), .fetch_en(fen_b),
        .hsync(hs_b), .vsync(vs_b), .rgb_out(rgb_b), .video_on(vid_b),
        .frame_start(fs_b), .line_start(ls_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int   falls[4];
    int   n_falls, hs_low, vs_low_a, vid01, ls01, blank_err, vid2, data_err;
    int   fs_t[4];
    int   n_fs, vid_w, ls_w, vs_w, hs_w, blank_b, vs_rise, fs_after, vs_after;
    logic prev_hs, prev_vs;

    initial begin
        rst_n_a  = 1'b0;
        rst_n_b  = 1'b0;
        rom_mode = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_hsync",   32'(hs_a),  1);
        check("rst_vsync",   32'(vs_a),  1);
        check("rst_rgb",     32'(rgb_a), 0);
        check("rst_video",   32'(vid_a), 0);
        check("rst_fetch_x", 32'(fx_a),  0);
        check("rst_fetch_y", 32'(fy_a),  0);
        check("rst_fs",      32'(fs_a),  0);
        check("rst_ls",      32'(ls_a),  0);

        // At the negedge numbered n after release the counters sit at h=n%800, v=n/800.
        rst_n_a = 1'b1;
        n_falls = 0; hs_low = 0; vs_low_a = 0; vid01 = 0; ls01 = 0;
        blank_err = 0; vid2 = 0; data_err = 0;
        prev_hs = 1'b1;
        for (int n = 1; n <= 2401; n++) begin
            @(negedge clk);
            if (n == 1) check("fs_cycle1", 32'(fs_a), 0);
            if (n == 2) begin
                check("fs_cycle2",    32'(fs_a),  1);
                check("ls_cycle2",    32'(ls_a),  1);
                check("vid_cycle2",   32'(vid_a), 1);
                check("fetch_x_cyc2", 32'(fx_a),  2);
            end
            if (n == 3) check("fs_cycle3", 32'(fs_a), 0);
            if (n <= 1601) begin
                if (prev_hs && !hs_a && n_falls < 4) begin
                    falls[n_falls] = n;
                    n_falls++;
                end
                if (!hs_a) hs_low++;
                if (!vs_a) vs_low_a++;
                if (vid_a) vid01++;
                if (ls_a) ls01++;
                if (rgb_a !== (vid_a ? 8'hFF : 8'h00)) blank_err++;
            end
            if (n == 1601) rom_mode = 1'b1;
            if (n >= 1602) begin
                if (vid_a) begin
                    vid2++;
                    if (rgb_a !== 8'(n - 1602)) data_err++;
                end else if (rgb_a !== 8'h00) begin
                    data_err++;
                end
                if (n == 1602) check("first_pixel", 32'(rgb_a), 32'h00);
                if (n == 2241) check("last_pixel",  32'(rgb_a), 32'h7F);
                if (n == 2242) check("vid_after_last", 32'(vid_a), 0);
            end
            if (n == 1602) check("fetch_en_h2",   32'(fen_a), 1);
            if (n == 1602) check("fetch_y_line2", 32'(fy_a),  2);
            if (n == 2239) check("fetch_en_h639", 32'(fen_a), 1);
            if (n == 2240) check("fetch_en_h640", 32'(fen_a), 0);
            prev_hs = hs_a;
        end
        check("hsync_falls",  32'(n_falls), 2);
        check("hsync_fall0",  32'(falls[0]), 658);
        check("hsync_fall1",  32'(falls[1]), 1458);
        check("hsync_low",    32'(hs_low), 192);
        check("vsync_low_l01", 32'(vs_low_a), 0);
        check("video_l01",    32'(vid01), 1280);
        check("ls_l01",       32'(ls01), 2);
        check("blank_err_a",  32'(blank_err), 0);
        check("video_l2",     32'(vid2), 640);
        check("data_err",     32'(data_err), 0);

        // Small instance: frame timing over roughly three frames.
        @(negedge clk);
        check("b_rst_hsync", 32'(hs_b), 0);
        check("b_rst_vsync", 32'(vs_b), 0);
        rst_n_b = 1'b1;
        n_fs = 0; vid_w = 0; ls_w = 0; vs_w = 0; hs_w = 0; blank_b = 0; vs_rise = -1;
        prev_vs = 1'b0;
        for (int m = 1; m <= 770; m++) begin
            @(negedge clk);
            if (fs_b && n_fs < 4) begin
                fs_t[n_fs] = m;
                n_fs++;
            end
            if (m >= 2 && m <= 276) begin
                if (vid_b) vid_w++;
                if (ls_b)  ls_w++;
                if (vs_b)  vs_w++;
                if (hs_b)  hs_w++;
                if (vs_b && !prev_vs && vs_rise < 0) vs_rise = m;
            end
            if (rgb_b !== (vid_b ? 8'hFF : 8'h00)) blank_b++;
            prev_vs = vs_b;
        end
        check("b_fs_count",   32'(n_fs), 3);
        check("b_fs_first",   32'(fs_t[0]), 2);
        check("b_fs_period1", 32'(fs_t[1] - fs_t[0]), 275);
        check("b_fs_period2", 32'(fs_t[2] - fs_t[1]), 275);
        check("b_video_frame", 32'(vid_w), 96);
        check("b_ls_frame",   32'(ls_w), 6);
        check("b_vsync_len",  32'(vs_w), 50);
        check("b_hsync_len",  32'(hs_w), 44);
        check("b_vsync_rise", 32'(vs_rise), 177);
        check("b_blank_err",  32'(blank_b), 0);

        // Counters now at (20,8): inside both vsync and hsync.
        check("b_vs_pre_rst", 32'(vs_b), 1);
        check("b_hs_pre_rst", 32'(hs_b), 1);
        rst_n_b = 1'b0;
        @(negedge clk);
        check("b_midrst_vsync", 32'(vs_b),  0);
        check("b_midrst_hsync", 32'(hs_b),  0);
        check("b_midrst_fx",    32'(fx_b),  0);
        check("b_midrst_fy",    32'(fy_b),  0);
        check("b_midrst_video", 32'(vid_b), 0);
        check("b_midrst_rgb",   32'(rgb_b), 0);
        @(negedge clk);
        rst_n_b = 1'b1;
        fs_after = -1; vs_after = 0;
        for (int k = 1; k <= 176; k++) begin
            @(negedge clk);
            if (fs_b && fs_after < 0) fs_after = k;
            if (vs_b) vs_after++;
        end
        check("b_fs_after_rst", 32'(fs_after), 2);
        check("b_vs_after_rst", 32'(vs_after), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
